cmd_exec: RTL and testbench

Parametrised command executor for the task-parser datapath: accepts 32-bit command words on a valid/ready stream, buffers them in a small FIFO, and executes them in order. BANK commands update NUM_BANKS per-bank value registers. OUT commands are presented on a held valid/ready output port. Malformed words are counted and optionally halt execution until software clears the error. It sits between the host command deframer and the bank/output logic, and generalises the fixed 4-bank / 8-bit / 5-bit command format to configurable widths.

---
 rtl/cmd_exec.sv | 177 +++++++++++++++++
 tb/tb_cmd_exec.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cmd_exec.sv
// Command executor: buffers 32-bit command words in a FIFO and executes them in order.
// Latency: a word accepted at edge k is popped/executed at edge k+1 at the earliest (no empty bypass).
// Backpressure: s_ready drops when DEPTH words are stored; an unaccepted OUT command stalls execution.
// Ports: clk/rst_n (sync, active-low); s_valid/s_ready/s_data command input stream;
//        out_valid/out_ready/out_cmd held OUT command port; bank_val packed bank registers;
//        err pulse, err_cnt saturating count, halted (STOP_ON_ERR=1), clr_err clears error state.
module cmd_exec #(
  parameter int NUM_BANKS   = 4,
  parameter int VAL_W       = 8,
  parameter int OUT_W       = 5,
  parameter int DEPTH       = 4,
  parameter bit STOP_ON_ERR = 1'b0
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       s_valid,
  output logic                       s_ready,
  input  logic [31:0]                s_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [OUT_W-1:0]           out_cmd,
  output logic [NUM_BANKS*VAL_W-1:0] bank_val,
  output logic                       err,
  output logic [7:0]                 err_cnt,
  output logic                       halted,
  input  logic                       clr_err
);

  localparam int AW = $clog2(DEPTH);

  // Reserved-bit masks: any set bit under the mask makes the word malformed.
  localparam logic [31:0] BANK_RSV = {4'h0, 20'(20'hFFFFF << VAL_W), 8'(8'hFF << NUM_BANKS)};
  localparam logic [31:0] OUT_RSV  = {4'h0, 28'(28'hFFFFFFF << OUT_W)};

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    OUT_WAIT = 2'd1,
    HALT     = 2'd2
  } state_t;

  state_t                       state_q, state_d;
  logic [31:0]                  mem_q [DEPTH];
  logic [31:0]                  mem_d [DEPTH];
  logic [AW-1:0]                wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]                rd_ptr_q, rd_ptr_d;
  logic [AW:0]                  count_q, count_d;
  logic [OUT_W-1:0]             out_cmd_q, out_cmd_d;
  logic [NUM_BANKS*VAL_W-1:0]   bank_val_q, bank_val_d;
  logic                         err_q, err_d;
  logic [7:0]                   err_cnt_q, err_cnt_d;

  logic [31:0] head;
  logic        fifo_empty;
  logic        fifo_full;
  logic        push;
  logic        pop;
  logic        is_bank;
  logic        is_out;
  logic        bad;
  logic [7:0]  err_base;

  assign head       = mem_q[rd_ptr_q];
  assign fifo_empty = (count_q == '0);
  // Fullness uses the registered count only, so a same-cycle pop never frees a slot for a push.
  assign fifo_full  = (count_q == (AW+1)'(DEPTH));
  assign s_ready    = rst_n && !fifo_full;
  assign push       = s_valid && s_ready;

  assign is_bank = (head[31:28] == 4'd0) && ((head & BANK_RSV) == 32'd0);
  assign is_out  = (head[31:28] == 4'd1) && ((head & OUT_RSV) == 32'd0);

  assign out_valid = (state_q == OUT_WAIT);
  assign out_cmd   = out_cmd_q;
  assign bank_val  = bank_val_q;
  assign err       = err_q;
  assign err_cnt   = err_cnt_q;
  assign halted    = (state_q == HALT);

  always_comb begin
    state_d    = state_q;
    mem_d      = mem_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    out_cmd_d  = out_cmd_q;
    bank_val_d = bank_val_q;
    err_d      = 1'b0;
    pop        = 1'b0;
    bad        = 1'b0;
    err_base   = clr_err ? 8'd0 : err_cnt_q;

    case (state_q)
      IDLE: begin
        pop = !fifo_empty;
      end
      OUT_WAIT: begin
        // Accept and fetch the next word on the same edge for 1/cycle OUT throughput.
        if (out_ready) begin
          state_d = IDLE;
          pop     = !fifo_empty;
        end
      end
      HALT: begin
        if (clr_err) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
      if (is_bank) begin
        for (int i = 0; i < NUM_BANKS; i++) begin
          if (head[i]) begin
            bank_val_d[i*VAL_W +: VAL_W] = head[8 +: VAL_W];
          end
        end
        state_d = IDLE;
      end else if (is_out) begin
        out_cmd_d = head[OUT_W-1:0];
        state_d   = OUT_WAIT;
      end else begin
        bad     = 1'b1;
        err_d   = 1'b1;
        state_d = STOP_ON_ERR ? HALT : IDLE;
      end
    end

    if (push) begin
      mem_d[wr_ptr_q] = s_data;
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end

    case ({push, pop})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase

    // A clear coinciding with a new error counts that error on top of the cleared value.
    err_cnt_d = err_base;
    if (bad) begin
      err_cnt_d = (err_base == 8'hFF) ? 8'hFF : err_base + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      out_cmd_q  <= '0;
      bank_val_q <= '0;
      err_q      <= 1'b0;
      err_cnt_q  <= 8'd0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      out_cmd_q  <= out_cmd_d;
      bank_val_q <= bank_val_d;
      err_q      <= err_d;
      err_cnt_q  <= err_cnt_d;
    end
  end

  // Storage needs no reset: the pointers/count define which entries are valid.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: tb/tb_cmd_exec.sv
module tb_cmd_exec;

  logic        clk;
  logic        rst_n;
  logic        s_valid;
  logic        s_ready;
  logic [31:0] s_data;
  logic        out_valid;
  logic        out_ready;
  logic [4:0]  out_cmd;
  logic [31:0] bank_val;
  logic        err;
  logic [7:0]  err_cnt;
  logic        halted;
  logic        clr_err;

  logic        h_s_valid;
  logic        h_s_ready;
  logic [31:0] h_s_data;
  logic        h_out_valid;
  logic        h_out_ready;
  logic [4:0]  h_out_cmd;
  logic [31:0] h_bank_val;
  logic        h_err;
  logic [7:0]  h_err_cnt;
  logic        h_halted;
  logic        h_clr_err;

  int n_cmp;
  int n_bad;

  cmd_exec #(.NUM_BANKS(4), .VAL_W(8), .OUT_W(5), .DEPTH(4), .STOP_ON_ERR(1'b0)) dut (
    .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_cmd(out_cmd), .bank_val(bank_val),
    .err(err), .err_cnt(err_cnt), .halted(halted), .clr_err(clr_err)
  );

  cmd_exec #(.NUM_BANKS(4), .VAL_W(8), .OUT_W(5), .DEPTH(4), .STOP_ON_ERR(1'b1)) dut_h (
    .clk(clk), .rst_n(rst_n), .s_valid(h_s_valid), .s_ready(h_s_ready), .s_data(h_s_data),
    .out_valid(h_out_valid), .out_ready(h_out_ready), .out_cmd(h_out_cmd), .bank_val(h_bank_val),
    .err(h_err), .err_cnt(h_err_cnt), .halted(h_halted), .clr_err(h_clr_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push_word(input logic [31:0] w);
    bit done;
    done    = 1'b0;
    s_valid = 1'b1;
    s_data  = w;
    for (int t = 0; t < 20 && !done; t++) begin
      if (s_ready) done = 1'b1;
      tick(1);
    end
    s_valid = 1'b0;
    if (!done) begin
      n_cmp++; n_bad++;
      $display("FAIL push_timeout: s_ready=%0b required 1 within 20 cycles", s_ready);
    end
  endtask

  task automatic h_push_word(input logic [31:0] w);
    bit done;
    done      = 1'b0;
    h_s_valid = 1'b1;
    h_s_data  = w;
    for (int t = 0; t < 20 && !done; t++) begin
      if (h_s_ready) done = 1'b1;
      tick(1);
    end
    h_s_valid = 1'b0;
    if (!done) begin
      n_cmp++; n_bad++;
      $display("FAIL h_push_timeout: h_s_ready=%0b required 1 within 20 cycles", h_s_ready);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick(3);
    n_cmp++; if (s_ready !== 1'b0) begin n_bad++; $display("FAIL rst_s_ready: got %0b want 0", s_ready); end
    n_cmp++; if (out_valid !== 1'b0 || out_cmd !== 5'd0) begin n_bad++; $display("FAIL rst_out: got v=%0b c=%h want 0/00", out_valid, out_cmd); end
    n_cmp++; if (bank_val !== 32'd0) begin n_bad++; $display("FAIL rst_bank: got %h want 00000000", bank_val); end
    n_cmp++; if (err !== 1'b0 || err_cnt !== 8'd0 || halted !== 1'b0) begin n_bad++; $display("FAIL rst_err: got err=%0b cnt=%0d halted=%0b want 0/0/0", err, err_cnt, halted); end
    rst_n = 1'b1;
    tick(1);
    n_cmp++; if (s_ready !== 1'b1) begin n_bad++; $display("FAIL rst_release_s_ready: got %0b want 1", s_ready); end
  endtask

  task automatic test_bank();
    push_word(32'h0000_AB05);
    // Word just written: no bypass, so nothing executed yet.
    n_cmp++; if (bank_val !== 32'd0) begin n_bad++; $display("FAIL bank_no_bypass: got %h want 00000000", bank_val); end
    tick(1);
    n_cmp++; if (bank_val !== 32'h00AB_00AB) begin n_bad++; $display("FAIL bank_load: got %h want 00ab00ab", bank_val); end
    n_cmp++; if (err !== 1'b0 || err_cnt !== 8'd0) begin n_bad++; $display("FAIL bank_err: got err=%0b cnt=%0d want 0/0", err, err_cnt); end
  endtask

  task automatic test_out_single();
    out_ready = 1'b1;
    push_word(32'h1000_0013);
    tick(1);
    n_cmp++; if (out_valid !== 1'b1 || out_cmd !== 5'h13) begin n_bad++; $display("FAIL out_single: got v=%0b c=%h want 1/13", out_valid, out_cmd); end
    tick(1);
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL out_single_drop: got v=%0b want 0", out_valid); end
  endtask

  task automatic test_back_to_back();
    logic [4:0] w [5];
    for (int i = 0; i < 5; i++) w[i] = 5'($urandom_range(0, 31));
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) push_word({4'h1, 23'd0, w[i]});
    n_cmp++; if (s_ready !== 1'b0) begin n_bad++; $display("FAIL bp_full: got s_ready=%0b want 0", s_ready); end
    n_cmp++; if (out_valid !== 1'b1 || out_cmd !== w[0]) begin n_bad++; $display("FAIL bp_hold: got v=%0b c=%h want 1/%h", out_valid, out_cmd, w[0]); end
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      n_cmp++;
      if (out_valid !== 1'b1 || out_cmd !== w[i]) begin
        n_bad++; $display("FAIL b2b_out[%0d]: got v=%0b c=%h want 1/%h", i, out_valid, out_cmd, w[i]);
      end
      tick(1);
    end
    n_cmp++; if (out_valid !== 1'b0 || s_ready !== 1'b1) begin n_bad++; $display("FAIL b2b_drain: got v=%0b rdy=%0b want 0/1", out_valid, s_ready); end
  endtask

  task automatic test_err_skip();
    push_word(32'h2000_0000);
    push_word(32'h0000_0101);
    n_cmp++; if (err !== 1'b1 || err_cnt !== 8'd1) begin n_bad++; $display("FAIL skip_err: got err=%0b cnt=%0d want 1/1", err, err_cnt); end
    n_cmp++; if (bank_val !== 32'h00AB_00AB) begin n_bad++; $display("FAIL skip_nochange: got %h want 00ab00ab", bank_val); end
    tick(1);
    n_cmp++; if (err !== 1'b0 || bank_val !== 32'h00AB_0001) begin n_bad++; $display("FAIL skip_next: got err=%0b bank=%h want 0/00ab0001", err, bank_val); end
    clr_err = 1'b1;
    tick(1);
    clr_err = 1'b0;
    n_cmp++; if (err_cnt !== 8'd0) begin n_bad++; $display("FAIL skip_clr: got cnt=%0d want 0", err_cnt); end
  endtask

  task automatic test_saturate();
    s_valid = 1'b1;
    s_data  = 32'hF000_0000;
    tick(270);
    s_valid = 1'b0;
    tick(3);
    n_cmp++; if (err_cnt !== 8'd255) begin n_bad++; $display("FAIL sat_cnt: got %0d want 255", err_cnt); end
    n_cmp++; if (halted !== 1'b0) begin n_bad++; $display("FAIL sat_halted: got %0b want 0", halted); end
  endtask

  task automatic test_halt();
    h_push_word(32'h0000_00F1);
    h_push_word(32'h0000_3302);
    tick(3);
    n_cmp++; if (h_halted !== 1'b1 || h_err_cnt !== 8'd1) begin n_bad++; $display("FAIL halt_set: got halted=%0b cnt=%0d want 1/1", h_halted, h_err_cnt); end
    n_cmp++; if (h_bank_val !== 32'd0) begin n_bad++; $display("FAIL halt_noexec: got %h want 00000000", h_bank_val); end
    h_clr_err = 1'b1;
    tick(1);
    h_clr_err = 1'b0;
    n_cmp++; if (h_halted !== 1'b0 || h_err_cnt !== 8'd0 || h_bank_val !== 32'd0) begin n_bad++; $display("FAIL halt_clr: got halted=%0b cnt=%0d bank=%h want 0/0/0", h_halted, h_err_cnt, h_bank_val); end
    tick(1);
    n_cmp++; if (h_bank_val !== 32'h0000_3300) begin n_bad++; $display("FAIL halt_resume: got %h want 00003300", h_bank_val); end
    // Two bad words queued; clearing the first halt while the second pops keeps the error.
    h_push_word(32'h3000_0000);
    h_push_word(32'h3000_0000);
    tick(2);
    h_clr_err = 1'b1;
    tick(2);
    h_clr_err = 1'b0;
    n_cmp++; if (h_halted !== 1'b1 || h_err_cnt !== 8'd1) begin n_bad++; $display("FAIL clr_vs_err: got halted=%0b cnt=%0d want 1/1", h_halted, h_err_cnt); end
    h_clr_err = 1'b1;
    tick(1);
    h_clr_err = 1'b0;
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b0;
    push_word(32'h1000_0007);
    push_word(32'h0000_FF0F);
    push_word(32'h1000_0009);
    n_cmp++; if (out_valid !== 1'b1 || out_cmd !== 5'h07) begin n_bad++; $display("FAIL mid_pending: got v=%0b c=%h want 1/07", out_valid, out_cmd); end
    rst_n = 1'b0;
    tick(1);
    n_cmp++; if (out_valid !== 1'b0 || out_cmd !== 5'd0 || bank_val !== 32'd0 || err_cnt !== 8'd0 || s_ready !== 1'b0) begin
      n_bad++; $display("FAIL mid_reset: got v=%0b c=%h bank=%h cnt=%0d rdy=%0b want 0/00/0/0/0", out_valid, out_cmd, bank_val, err_cnt, s_ready);
    end
    rst_n = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick(1);
      n_cmp++;
      if (out_valid !== 1'b0 || bank_val !== 32'd0) begin
        n_bad++; $display("FAIL mid_stale[%0d]: got v=%0b bank=%h want 0/00000000", i, out_valid, bank_val);
      end
    end
  endtask

  function automatic logic [31:0] rand_word();
    logic [31:0] w;
    case ($urandom_range(0, 3))
      0: w = {4'h0, 12'h0, 8'($urandom), 4'h0, 4'($urandom)};
      1: w = {4'h1, 23'h0, 5'($urandom)};
      2: w = {4'($urandom_range(2, 15)), 28'($urandom)};
      default: w = ($urandom_range(0, 1) == 0) ? {4'h0, 28'($urandom) | 28'h0000010} :
                                                 {4'h1, 28'($urandom) | 28'h0000020};
    endcase
    return w;
  endfunction

  // Reference: each accepted word is classified by the command rules; banks keep their last
  // written value, legal OUT fields are expected in acceptance order, malformed words counted.
  task automatic test_random();
    logic [7:0]  exp_bank [4];
    logic [4:0]  exp_out [$];
    logic [4:0]  want;
    logic [31:0] w;
    logic [31:0] exp_bv;
    int          exp_err;
    int          obs_err;
    bit          hold;
    logic [4:0]  hold_cmd;
    for (int i = 0; i < 4; i++) exp_bank[i] = 8'd0;
    exp_err = 0; obs_err = 0; hold = 1'b0; hold_cmd = 5'd0;
    clr_err = 1'b1;
    tick(1);
    clr_err = 1'b0;
    n_cmp++; if (err_cnt !== 8'd0) begin n_bad++; $display("FAIL rand_start_cnt: got %0d want 0", err_cnt); end
    for (int c = 0; c < 340; c++) begin
      if (c < 300) begin
        s_valid   = ($urandom_range(0, 3) != 0);
        s_data    = rand_word();
        out_ready = ($urandom_range(0, 2) != 0);
      end else begin
        s_valid   = 1'b0;
        out_ready = 1'b1;
      end
      if (hold) begin
        n_cmp++;
        if (out_valid !== 1'b1 || out_cmd !== hold_cmd) begin
          n_bad++; $display("FAIL rand_hold: got v=%0b c=%h want 1/%h", out_valid, out_cmd, hold_cmd);
        end
      end
      hold     = out_valid && !out_ready;
      hold_cmd = out_cmd;
      if (out_valid && out_ready) begin
        n_cmp++;
        if (exp_out.size() == 0) begin
          n_bad++; $display("FAIL rand_out_extra: got c=%h want no output", out_cmd);
        end else begin
          want = exp_out.pop_front();
          if (out_cmd !== want) begin n_bad++; $display("FAIL rand_out: got %h want %h", out_cmd, want); end
        end
      end
      if (s_valid && s_ready) begin
        w = s_data;
        if (w[31:28] == 4'd0 && w[27:16] == 12'd0 && w[7:4] == 4'd0) begin
          for (int b = 0; b < 4; b++) if (w[b]) exp_bank[b] = w[15:8];
        end else if (w[31:28] == 4'd1 && w[27:5] == 23'd0) begin
          exp_out.push_back(w[4:0]);
        end else begin
          exp_err++;
        end
      end
      tick(1);
      if (err === 1'b1) obs_err++;
    end
    exp_bv = {exp_bank[3], exp_bank[2], exp_bank[1], exp_bank[0]};
    n_cmp++; if (exp_out.size() != 0) begin n_bad++; $display("FAIL rand_out_missing: got %0d unseen want 0", exp_out.size()); end
    n_cmp++; if (bank_val !== exp_bv) begin n_bad++; $display("FAIL rand_bank: got %h want %h", bank_val, exp_bv); end
    n_cmp++; if (err_cnt !== 8'((exp_err > 255) ? 255 : exp_err)) begin n_bad++; $display("FAIL rand_err_cnt: got %0d want %0d", err_cnt, exp_err); end
    n_cmp++; if (obs_err != exp_err) begin n_bad++; $display("FAIL rand_err_pulses: got %0d want %0d", obs_err, exp_err); end
  endtask

  initial begin
    n_cmp = 0; n_bad = 0;
    rst_n = 1'b0; s_valid = 1'b0; s_data = 32'd0; out_ready = 1'b0; clr_err = 1'b0;
    h_s_valid = 1'b0; h_s_data = 32'd0; h_out_ready = 1'b1; h_clr_err = 1'b0;
    test_reset();
    test_bank();
    test_out_single();
    test_back_to_back();
    test_err_skip();
    test_halt();
    test_saturate();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
